// File: rtl/cache_axi_bridge.sv
// Cache-to-AXI bridge: converts cache miss/uncached reads and write-backs into
// AXI read/write bursts with independent engines and a same-line RAW guard.
module cache_axi_bridge (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic         arvalid,
  input  logic         arready,
  input  logic [31:0]  rdata,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic         bvalid,
  output logic         bready
);

  localparam logic [2:0]  TYPE_LINE = 3'b100;
  localparam logic [7:0]  LEN_LINE  = 8'd3;
  localparam logic [7:0]  LEN_WORD  = 8'd0;
  localparam int unsigned CNT_W     = 2;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_t;

  rd_state_t          rd_state, rd_next;
  wr_state_t          wr_state, wr_next;
  logic [127:0]       wr_buf;
  logic [3:0]         wr_strb_q;
  logic               wr_line;
  logic [CNT_W-1:0]   wr_cnt;
  logic               hazard;

  // A read to the line currently being written back must wait for its B response.
  assign hazard = (wr_state != W_IDLE) && (rd_addr[31:4] == awaddr[31:4]);

  assign wdata = wr_buf[{wr_cnt, 5'd0} +: 32];
  assign wstrb = wr_line ? 4'hf : wr_strb_q;

  always_ff @(posedge clk) begin
    if (reset) rd_state <= R_IDLE;
    else       rd_state <= rd_next;
  end

  always_comb begin
    rd_next   = rd_state;
    rd_rdy    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    ret_data  = rdata;
    case (rd_state)
      R_IDLE: begin
        rd_rdy = !hazard;
        if (rd_req && !hazard) rd_next = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) rd_next = R_DATA;
      end
      R_DATA: begin
        rready    = 1'b1;
        ret_valid = rvalid;
        ret_last  = rvalid && rlast;
        if (rvalid && rlast) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // Read address/length captured on request acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      araddr <= 32'd0;
      arlen  <= 8'd0;
    end else if (rd_state == R_IDLE && rd_req && !hazard) begin
      araddr <= rd_addr;
      arlen  <= (rd_type == TYPE_LINE) ? LEN_LINE : LEN_WORD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wr_state <= W_IDLE;
    else       wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    wr_rdy  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wlast   = 1'b0;
    bready  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        wr_rdy = 1'b1;
        if (wr_req) wr_next = W_AW;
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) wr_next = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        wlast  = (8'(wr_cnt) == awlen);
        if (wready && wlast) wr_next = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  // Write request capture and beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      awaddr    <= 32'd0;
      awlen     <= 8'd0;
      wr_buf    <= 128'd0;
      wr_strb_q <= 4'd0;
      wr_line   <= 1'b0;
      wr_cnt    <= CNT_W'(0);
    end else if (wr_state == W_IDLE && wr_req) begin
      awaddr    <= wr_addr;
      awlen     <= (wr_type == TYPE_LINE) ? LEN_LINE : LEN_WORD;
      wr_buf    <= wr_data;
      wr_strb_q <= wr_wstrb;
      wr_line   <= (wr_type == TYPE_LINE);
      wr_cnt    <= CNT_W'(0);
    end else if (wr_state == W_DATA && wready && !wlast) begin
      wr_cnt    <= wr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: transaction-level scoreboard for the
// AXI channels and return path, plus hand-computed cycle-level expectations.
module tb_cache_axi_bridge;

  logic         clk, reset;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic         arvalid, arready;
  logic [31:0]  rdata;
  logic         rlast, rvalid, rready;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic         awvalid, awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast, wvalid, wready, bvalid, bready;

  cache_axi_bridge dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; } addr_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } wbeat_t;
  typedef struct { logic [31:0] data; logic last; } ret_t;

  addr_t  ar_q[$];
  addr_t  aw_q[$];
  wbeat_t w_q[$];
  ret_t   ret_q[$];

  int checks = 0;
  int failures = 0;
  int ret_pulses = 0;
  logic [31:0] t3w [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hc0de_0000;
  endfunction

  // Expected transactions for a cache request, derived from the request alone.
  task automatic model_read(input logic [31:0] a, input logic line);
    int n;
    n = line ? 4 : 1;
    ar_q.push_back('{a, line ? 8'd3 : 8'd0});
    for (int i = 0; i < n; i++)
      ret_q.push_back('{mem_word(a + 32'(4 * i)), (i == n - 1)});
  endtask

  task automatic model_write(input logic [31:0] a, input logic line,
                             input logic [3:0] strb, input logic [127:0] d);
    int n;
    n = line ? 4 : 1;
    aw_q.push_back('{a, line ? 8'd3 : 8'd0});
    for (int i = 0; i < n; i++)
      w_q.push_back('{d[32 * i +: 32], line ? 4'hf : strb, (i == n - 1)});
  endtask

  // Scoreboard: every cycle a channel is valid its payload must match the head.
  always @(negedge clk) begin
    if (!reset) begin
      if (arvalid) begin
        if (ar_q.size() == 0) chk("ar_unexpected", {63'd0, arvalid}, 64'd0);
        else begin
          chk("sb_araddr", araddr, ar_q[0].addr);
          chk("sb_arlen", arlen, ar_q[0].len);
          if (arready) void'(ar_q.pop_front());
        end
      end
      if (awvalid) begin
        if (aw_q.size() == 0) chk("aw_unexpected", {63'd0, awvalid}, 64'd0);
        else begin
          chk("sb_awaddr", awaddr, aw_q[0].addr);
          chk("sb_awlen", awlen, aw_q[0].len);
          if (awready) void'(aw_q.pop_front());
        end
      end
      if (wvalid) begin
        if (w_q.size() == 0) chk("w_unexpected", {63'd0, wvalid}, 64'd0);
        else begin
          chk("sb_wdata", wdata, w_q[0].data);
          chk("sb_wstrb", wstrb, w_q[0].strb);
          chk("sb_wlast", wlast, w_q[0].last);
          if (wready) void'(w_q.pop_front());
        end
      end
      if (ret_valid) begin
        ret_pulses++;
        if (ret_q.size() == 0) chk("ret_unexpected", {63'd0, ret_valid}, 64'd0);
        else begin
          chk("sb_ret_data", ret_data, ret_q[0].data);
          chk("sb_ret_last", ret_last, ret_q[0].last);
          void'(ret_q.pop_front());
        end
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rd_req = 0; rd_type = 0; rd_addr = 0;
    wr_req = 0; wr_type = 0; wr_addr = 0; wr_wstrb = 0; wr_data = 0;
    arready = 0; rdata = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;
    t3w[0] = 32'h11110000; t3w[1] = 32'h22220001;
    t3w[2] = 32'h33330002; t3w[3] = 32'h44440003;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    smp;
    chk("rst_rd_rdy", rd_rdy, 1);
    chk("rst_wr_rdy", wr_rdy, 1);
    chk("rst_ctrl", {arvalid, rready, awvalid, wvalid, wlast, bready, ret_valid, ret_last}, 8'h00);
    chk("rst_addr", {araddr, awaddr}, 64'd0);
    chk("rst_len_strb", {arlen, awlen, wstrb}, 20'd0);
    chk("rst_wdata", wdata, 32'd0);

    // Line read, arready delayed two cycles, one gap after each R beat
    cyc; rd_req = 1; rd_type = 3'b100; rd_addr = 32'h1c000010;
    model_read(32'h1c000010, 1'b1);
    smp; chk("t1_rd_rdy_accept", rd_rdy, 1);
    cyc; rd_req = 0;
    smp; chk("t1_arvalid", arvalid, 1); chk("t1_araddr", araddr, 32'h1c000010);
    chk("t1_arlen", arlen, 8'd3); chk("t1_rd_rdy_busy", rd_rdy, 0);
    cyc; smp; chk("t1_arvalid_hold", arvalid, 1);
    cyc; arready = 1;
    smp;
    for (int i = 0; i < 4; i++) begin
      cyc; arready = 0; rvalid = 1; rlast = (i == 3);
      rdata = mem_word(32'h1c000010 + 32'(4 * i));
      smp; chk("t1_ret_valid", ret_valid, 1); chk("t1_ret_last", ret_last, (i == 3));
      chk("t1_rready", rready, 1); chk("t1_rd_rdy_beat", rd_rdy, 0);
      cyc; rvalid = 0; rlast = 0;
      smp;
      if (i < 3) begin
        chk("t1_gap_ret_valid", ret_valid, 0); chk("t1_rd_rdy_gap", rd_rdy, 0);
      end else begin
        chk("t1_rd_rdy_back", rd_rdy, 1);
      end
    end

    // Word write: single beat carries word 0 of the buffer
    cyc; wr_req = 1; wr_type = 3'b010; wr_addr = 32'hbfaf8004; wr_wstrb = 4'b0011;
    wr_data = {32'h33333333, 32'h22222222, 32'h12345678, 32'ha5a50001};
    model_write(wr_addr, 1'b0, wr_wstrb, wr_data);
    smp; chk("t2_wr_rdy_idle", wr_rdy, 1);
    cyc; wr_req = 0; awready = 1;
    smp; chk("t2_awvalid", awvalid, 1); chk("t2_awaddr", awaddr, 32'hbfaf8004);
    chk("t2_awlen", awlen, 8'd0); chk("t2_wr_rdy_busy", wr_rdy, 0);
    cyc; awready = 0; wready = 1;
    smp; chk("t2_wvalid", wvalid, 1); chk("t2_wdata", wdata, 32'ha5a50001);
    chk("t2_wstrb", wstrb, 4'b0011); chk("t2_wlast", wlast, 1);
    cyc; wready = 0;
    smp; chk("t2_bready", bready, 1); chk("t2_wvalid_done", wvalid, 0); chk("t2_wr_rdy_resp", wr_rdy, 0);
    cyc; bvalid = 1;
    smp; chk("t2_wr_rdy_bhs", wr_rdy, 0);
    cyc; bvalid = 0;
    smp; chk("t2_wr_rdy_back", wr_rdy, 1); chk("t2_bready_off", bready, 0);

    // Line write with wready alternating 0/1
    cyc; wr_req = 1; wr_type = 3'b100; wr_addr = 32'h00004560; wr_wstrb = 4'b0001;
    wr_data = {t3w[3], t3w[2], t3w[1], t3w[0]};
    model_write(wr_addr, 1'b1, wr_wstrb, wr_data);
    smp;
    cyc; wr_req = 0; awready = 1;
    smp; chk("t3_awlen", awlen, 8'd3);
    cyc; awready = 0;
    for (int k = 0; k < 4; k++) begin
      wready = 0;
      smp; chk("t3_wdata_hold", wdata, t3w[k]); chk("t3_wlast_hold", wlast, (k == 3));
      chk("t3_wstrb", wstrb, 4'hf);
      cyc; wready = 1;
      smp; chk("t3_wdata", wdata, t3w[k]);
      cyc;
    end
    wready = 0; bvalid = 1;
    smp; chk("t3_bready", bready, 1);
    cyc; bvalid = 0;
    smp; chk("t3_wr_rdy_back", wr_rdy, 1);

    // Same-line hazard, with an unrelated read passing during the write
    cyc; wr_req = 1; wr_type = 3'b100; wr_addr = 32'h00001230;
    wr_data = {32'hd0000003, 32'hd0000002, 32'hd0000001, 32'hd0000000};
    model_write(wr_addr, 1'b1, 4'h0, wr_data);
    smp;
    cyc; wr_req = 0; rd_req = 1; rd_type = 3'b010; rd_addr = 32'h00002000;
    model_read(32'h00002000, 1'b0);
    smp; chk("t4_awvalid", awvalid, 1); chk("t4_nomatch_rd_rdy", rd_rdy, 1);
    cyc; rd_req = 0; arready = 1; awready = 1;
    smp; chk("t4_arvalid", arvalid, 1);
    cyc; arready = 0; awready = 0; rvalid = 1; rlast = 1; rdata = mem_word(32'h00002000); wready = 1;
    smp; chk("t4_ret_valid", ret_valid, 1); chk("t4_wvalid", wvalid, 1);
    cyc; rvalid = 0; rlast = 0; rd_req = 1; rd_type = 3'b010; rd_addr = 32'h0000123c;
    smp; chk("t4_hazard_rd_rdy", rd_rdy, 0);
    repeat (2) begin
      cyc; smp; chk("t4_hazard_hold", rd_rdy, 0);
    end
    cyc; wready = 0;
    smp; chk("t4_bready", bready, 1); chk("t4_hazard_resp", rd_rdy, 0);
    cyc; bvalid = 1;
    smp; chk("t4_hazard_bhs", rd_rdy, 0);
    cyc; bvalid = 0; model_read(32'h0000123c, 1'b0);
    smp; chk("t4_hazard_clear", rd_rdy, 1);
    cyc; rd_req = 0; arready = 1;
    smp; chk("t4_araddr", araddr, 32'h0000123c);
    cyc; arready = 0; rvalid = 1; rlast = 1; rdata = mem_word(32'h0000123c);
    smp; chk("t4_ret_last", ret_last, 1);
    cyc; rvalid = 0; rlast = 0;
    smp; chk("t4_rd_rdy_back", rd_rdy, 1);

    // Reset during the second R beat of a line read
    cyc; rd_req = 1; rd_type = 3'b100; rd_addr = 32'h00003000;
    model_read(32'h00003000, 1'b1);
    smp;
    cyc; rd_req = 0; arready = 1;
    smp;
    cyc; arready = 0; rvalid = 1; rlast = 0; rdata = mem_word(32'h00003000);
    smp; chk("t5_beat0", ret_valid, 1);
    cyc; rdata = mem_word(32'h00003004); reset = 1;
    smp;
    cyc; reset = 0; rvalid = 0;
    ar_q.delete(); aw_q.delete(); w_q.delete(); ret_q.delete();
    smp;
    chk("t5_rd_rdy", rd_rdy, 1); chk("t5_wr_rdy", wr_rdy, 1);
    chk("t5_ctrl", {arvalid, rready, awvalid, wvalid, wlast, bready, ret_valid, ret_last}, 8'h00);
    chk("t5_araddr", araddr, 32'd0);
    cyc; rd_req = 1; rd_type = 3'b100; rd_addr = 32'h00005550;
    model_read(32'h00005550, 1'b1);
    smp; chk("t5_accept", rd_rdy, 1);
    cyc; rd_req = 0; arready = 1;
    smp; chk("t5_new_araddr", araddr, 32'h00005550);
    cyc; arready = 0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rlast = (i == 3); rdata = mem_word(32'h00005550 + 32'(4 * i));
      smp; chk("t5_ret_last", ret_last, (i == 3));
      cyc;
    end
    rvalid = 0; rlast = 0;
    smp; chk("t5_rd_rdy_back", rd_rdy, 1);

    cyc; cyc;
    chk("queues_empty", 64'(ar_q.size() + aw_q.size() + w_q.size() + ret_q.size()), 64'd0);
    chk("ret_pulse_total", 64'(ret_pulses), 64'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
